// File: rtl/common.sv
// rtl/common.sv - shared load/store types, store queue sizing, func3 codes and robid age compare
package common;

  localparam int ROB_WIDTH        = 5;
  localparam int SQ_DEPTH_DEFAULT = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef logic [ROB_WIDTH:0] robid_t;

  typedef struct packed {
    logic        valid;
    logic        committed;
    robid_t      robid;
    logic [31:0] pc;
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sq_entry_t;

  // True when robid a is strictly younger than robid b; the MSB is the ROB wrap bit.
  function automatic logic robid_younger(input robid_t a, input robid_t b);
    return a[ROB_WIDTH] ^ b[ROB_WIDTH] ^ (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/sq_fwd_mux.sv
// rtl/sq_fwd_mux.sv - per-lane youngest-match store-to-load forwarding select
module sq_fwd_mux
  import common::*;
#(
  parameter int SQ_DEPTH = SQ_DEPTH_DEFAULT,
  localparam int IDX_W = $clog2(SQ_DEPTH)
) (
  input  logic [SQ_DEPTH-1:0] ent_valid,
  input  logic [29:0]         ent_waddr [SQ_DEPTH],
  input  logic [31:0]         ent_data  [SQ_DEPTH],
  input  logic [3:0]          ent_strb  [SQ_DEPTH],
  input  logic [IDX_W-1:0]    head_idx,
  input  logic [29:0]         load_waddr,
  output logic [31:0]         fwd_data,
  output logic [3:0]          fwd_byte_vector
);

  logic [IDX_W-1:0] idx;

  // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
  always_comb begin
    fwd_data        = '0;
    fwd_byte_vector = '0;
    idx             = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = head_idx + IDX_W'(i);
      if (ent_valid[idx] && (ent_waddr[idx] == load_waddr)) begin
        for (int j = 0; j < 4; j++) begin
          if (ent_strb[idx][j]) begin
            fwd_byte_vector[j]  = 1'b1;
            fwd_data[8*j +: 8]  = ent_data[idx][8*j +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue: alloc, ROB commit, dmem drain, flush squash, forwarding
module store_queue
  import common::*;
#(
  parameter int SQ_DEPTH = SQ_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_valid,
  input  logic [ROB_WIDTH:0] flush_robid,
  input  logic               lsuint2sq_instr0_valid,
  input  logic [ROB_WIDTH:0] lsuint2sq_instr0_robid,
  input  logic [31:0]        lsuint2sq_instr0_pc,
  input  logic [31:0]        lsuint2sq_wb_addr,
  input  logic [31:0]        lsuint2sq_wb_data,
  input  logic [2:0]         lsuint2sq_wb_func3,
  input  logic               rob_commit_valid,
  input  logic [ROB_WIDTH:0] rob_commit_robid,
  input  logic [31:0]        load_addr,
  output logic [31:0]        sq_fwd_data,
  output logic [3:0]         sq_fwd_byte_vector,
  output logic               sq_fwd_valid,
  output logic [1:0]         sq_left,
  output logic               mem_write_req,
  output logic [31:0]        mem_write_addr,
  output logic [31:0]        mem_write_data,
  output logic [3:0]         mem_write_strb,
  input  logic               mem_write_ack,
  output logic               sq_empty
);

  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  sq_entry_t          entries [SQ_DEPTH];
  logic [PTR_W-1:0]   head_ptr, commit_ptr, tail_ptr;
  logic [PTR_W-1:0]   count, free_cnt, flush_tail;
  logic [PTR_W-1:0]   scan_ptr [SQ_DEPTH];
  logic [IDX_W-1:0]   head_idx, commit_idx, tail_idx, scan_idx;
  logic               full, commit_ok, alloc_ok, pop, flush_hit;
  logic [SQ_DEPTH-1:0] squash;
  sq_entry_t          new_entry;

  logic [SQ_DEPTH-1:0] ent_valid;
  logic [29:0]         ent_waddr [SQ_DEPTH];
  logic [31:0]         ent_data  [SQ_DEPTH];
  logic [3:0]          ent_strb  [SQ_DEPTH];

  assign head_idx   = head_ptr[IDX_W-1:0];
  assign commit_idx = commit_ptr[IDX_W-1:0];
  assign tail_idx   = tail_ptr[IDX_W-1:0];
  assign count      = tail_ptr - head_ptr;
  assign full       = (head_ptr[IDX_W] != tail_ptr[IDX_W]) && (head_idx == tail_idx);

  assign mem_write_req = entries[head_idx].valid & entries[head_idx].committed;
  assign pop           = mem_write_req & mem_write_ack;
  assign commit_ok     = rob_commit_valid && (commit_ptr != tail_ptr);
  assign alloc_ok      = lsuint2sq_instr0_valid && !flush_valid && !full;

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.robid     = lsuint2sq_instr0_robid;
    new_entry.pc        = lsuint2sq_instr0_pc;
    new_entry.waddr     = lsuint2sq_wb_addr[31:2];
    case (lsuint2sq_wb_func3)
      F3_SB: begin
        new_entry.strb = 4'b0001 << lsuint2sq_wb_addr[1:0];
        new_entry.data = lsuint2sq_wb_data << {lsuint2sq_wb_addr[1:0], 3'b000};
      end
      F3_SH: begin
        new_entry.strb = lsuint2sq_wb_addr[1] ? 4'b1100 : 4'b0011;
        new_entry.data = lsuint2sq_wb_addr[1] ? {lsuint2sq_wb_data[15:0], 16'h0000}
                                              : {16'h0000, lsuint2sq_wb_data[15:0]};
      end
      default: begin
        new_entry.strb = 4'hF;
        new_entry.data = lsuint2sq_wb_data;
      end
    endcase
  end

  // Uncommitted younger stores form a contiguous suffix; the first one found becomes the new tail.
  always_comb begin
    squash     = '0;
    flush_hit  = 1'b0;
    flush_tail = tail_ptr;
    scan_idx   = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      scan_ptr[i] = head_ptr + PTR_W'(i);
      scan_idx    = scan_ptr[i][IDX_W-1:0];
      if (flush_valid && (PTR_W'(i) < count) && entries[scan_idx].valid &&
          !entries[scan_idx].committed && !(commit_ok && (scan_idx == commit_idx)) &&
          robid_younger(entries[scan_idx].robid, flush_robid)) begin
        squash[scan_idx] = 1'b1;
        if (!flush_hit) begin
          flush_hit  = 1'b1;
          flush_tail = scan_ptr[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr   <= '0;
      commit_ptr <= '0;
      tail_ptr   <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (lsuint2sq_instr0_valid && !flush_valid)
        assert (!full) else $warning("store_queue: allocate while full, request dropped");
      if (rob_commit_valid) begin
        assert (commit_ptr != tail_ptr) else $error("store_queue: commit with no uncommitted store");
        if (commit_ptr != tail_ptr)
          assert (entries[commit_idx].robid == rob_commit_robid)
            else $error("store_queue: commit robid does not match queued store");
      end

      if (commit_ok) begin
        entries[commit_idx].committed <= 1'b1;
        commit_ptr                    <= commit_ptr + 1'b1;
      end
      if (pop) begin
        entries[head_idx] <= '0;
        head_ptr          <= head_ptr + 1'b1;
      end
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (squash[i]) entries[i] <= '0;
      end
      if (flush_hit) begin
        tail_ptr <= flush_tail;
      end else if (alloc_ok) begin
        entries[tail_idx] <= new_entry;
        tail_ptr          <= tail_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      ent_valid[i] = entries[i].valid;
      ent_waddr[i] = entries[i].waddr;
      ent_data[i]  = entries[i].data;
      ent_strb[i]  = entries[i].strb;
    end
  end

  sq_fwd_mux #(.SQ_DEPTH(SQ_DEPTH)) u_fwd_mux (
    .ent_valid       (ent_valid),
    .ent_waddr       (ent_waddr),
    .ent_data        (ent_data),
    .ent_strb        (ent_strb),
    .head_idx        (head_idx),
    .load_waddr      (load_addr[31:2]),
    .fwd_data        (sq_fwd_data),
    .fwd_byte_vector (sq_fwd_byte_vector)
  );

  assign sq_fwd_valid   = &sq_fwd_byte_vector;
  assign mem_write_addr = mem_write_req ? {entries[head_idx].waddr, 2'b00} : '0;
  assign mem_write_data = mem_write_req ? entries[head_idx].data : '0;
  assign mem_write_strb = mem_write_req ? entries[head_idx].strb : '0;

  assign free_cnt = PTR_W'(SQ_DEPTH) - count;
  assign sq_left  = (free_cnt > PTR_W'(3)) ? 2'd3 : free_cnt[1:0];
  assign sq_empty = (count == '0);

  // The pc is kept for debug visibility only.
  logic unused_sigs;
  assign unused_sigs = ^{load_addr[1:0], entries[head_idx].pc};

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue
module tb_store_queue;
  import common::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               flush_valid;
  logic [ROB_WIDTH:0] flush_robid;
  logic               lsuint2sq_instr0_valid;
  logic [ROB_WIDTH:0] lsuint2sq_instr0_robid;
  logic [31:0]        lsuint2sq_instr0_pc;
  logic [31:0]        lsuint2sq_wb_addr;
  logic [31:0]        lsuint2sq_wb_data;
  logic [2:0]         lsuint2sq_wb_func3;
  logic               rob_commit_valid;
  logic [ROB_WIDTH:0] rob_commit_robid;
  logic [31:0]        load_addr;
  logic [31:0]        sq_fwd_data;
  logic [3:0]         sq_fwd_byte_vector;
  logic               sq_fwd_valid;
  logic [1:0]         sq_left;
  logic               mem_write_req;
  logic [31:0]        mem_write_addr;
  logic [31:0]        mem_write_data;
  logic [3:0]         mem_write_strb;
  logic               mem_write_ack;
  logic               sq_empty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  store_queue dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .flush_valid            (flush_valid),
    .flush_robid            (flush_robid),
    .lsuint2sq_instr0_valid (lsuint2sq_instr0_valid),
    .lsuint2sq_instr0_robid (lsuint2sq_instr0_robid),
    .lsuint2sq_instr0_pc    (lsuint2sq_instr0_pc),
    .lsuint2sq_wb_addr      (lsuint2sq_wb_addr),
    .lsuint2sq_wb_data      (lsuint2sq_wb_data),
    .lsuint2sq_wb_func3     (lsuint2sq_wb_func3),
    .rob_commit_valid       (rob_commit_valid),
    .rob_commit_robid       (rob_commit_robid),
    .load_addr              (load_addr),
    .sq_fwd_data            (sq_fwd_data),
    .sq_fwd_byte_vector     (sq_fwd_byte_vector),
    .sq_fwd_valid           (sq_fwd_valid),
    .sq_left                (sq_left),
    .mem_write_req          (mem_write_req),
    .mem_write_addr         (mem_write_addr),
    .mem_write_data         (mem_write_data),
    .mem_write_strb         (mem_write_strb),
    .mem_write_ack          (mem_write_ack),
    .sq_empty               (sq_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush_valid            = 1'b0;
    flush_robid            = '0;
    lsuint2sq_instr0_valid = 1'b0;
    lsuint2sq_instr0_robid = '0;
    lsuint2sq_instr0_pc    = '0;
    lsuint2sq_wb_addr      = '0;
    lsuint2sq_wb_data      = '0;
    lsuint2sq_wb_func3     = F3_SW;
    rob_commit_valid       = 1'b0;
    rob_commit_robid       = '0;
    load_addr              = '0;
    mem_write_ack          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic alloc(input logic [ROB_WIDTH:0] rid, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    lsuint2sq_instr0_valid = 1'b1;
    lsuint2sq_instr0_robid = rid;
    lsuint2sq_instr0_pc    = 32'h1000 + {26'd0, rid};
    lsuint2sq_wb_addr      = a;
    lsuint2sq_wb_data      = d;
    lsuint2sq_wb_func3     = f3;
    tick();
    lsuint2sq_instr0_valid = 1'b0;
  endtask

  task automatic commit(input logic [ROB_WIDTH:0] rid);
    rob_commit_valid = 1'b1;
    rob_commit_robid = rid;
    tick();
    rob_commit_valid = 1'b0;
  endtask

  task automatic ack_once();
    mem_write_ack = 1'b1;
    tick();
    mem_write_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sq_left !== 2'd3) begin n_bad++; $display("FAIL reset_sq_left got %0d want 3", sq_left); end
    n_cmp++; if (sq_empty !== 1'b1) begin n_bad++; $display("FAIL reset_sq_empty got %b want 1", sq_empty); end
    n_cmp++; if (mem_write_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", mem_write_req); end
    n_cmp++; if ({mem_write_addr, mem_write_data, mem_write_strb} !== 68'd0) begin
      n_bad++; $display("FAIL reset_mem_bus got %h/%h/%h want zeros", mem_write_addr, mem_write_data, mem_write_strb); end
    n_cmp++; if ({sq_fwd_data, sq_fwd_byte_vector, sq_fwd_valid} !== 37'd0) begin
      n_bad++; $display("FAIL reset_fwd got %h/%b/%b want zeros", sq_fwd_data, sq_fwd_byte_vector, sq_fwd_valid); end
  endtask

  task automatic test_sw_forward();
    do_reset();
    alloc(6'd0, 32'h100, 32'hAABBCCDD, F3_SW);
    load_addr = 32'h100;
    #1;
    n_cmp++; if (sq_fwd_valid !== 1'b1) begin n_bad++; $display("FAIL sw_fwd_valid got %b want 1", sq_fwd_valid); end
    n_cmp++; if (sq_fwd_byte_vector !== 4'hF) begin n_bad++; $display("FAIL sw_fwd_vec got %b want 1111", sq_fwd_byte_vector); end
    n_cmp++; if (sq_fwd_data !== 32'hAABBCCDD) begin n_bad++; $display("FAIL sw_fwd_data got %h want aabbccdd", sq_fwd_data); end
    n_cmp++; if (sq_left !== 2'd3 || sq_empty !== 1'b0) begin
      n_bad++; $display("FAIL sw_one_entry got left=%0d empty=%b want left=3 empty=0", sq_left, sq_empty); end
    load_addr = 32'h104;
    #1;
    n_cmp++; if (sq_fwd_byte_vector !== 4'h0) begin n_bad++; $display("FAIL sw_other_word got %b want 0000", sq_fwd_byte_vector); end
  endtask

  task automatic test_byte_forward();
    do_reset();
    alloc(6'd0, 32'h201, 32'h11, F3_SB);
    alloc(6'd1, 32'h201, 32'h22, F3_SB);
    load_addr = 32'h200;
    #1;
    n_cmp++; if (sq_fwd_byte_vector !== 4'b0010) begin n_bad++; $display("FAIL sb_vec got %b want 0010", sq_fwd_byte_vector); end
    n_cmp++; if (sq_fwd_data !== 32'h0000_2200) begin n_bad++; $display("FAIL sb_youngest_data got %h want 00002200", sq_fwd_data); end
    n_cmp++; if (sq_fwd_valid !== 1'b0) begin n_bad++; $display("FAIL sb_fwd_valid got %b want 0", sq_fwd_valid); end
    alloc(6'd2, 32'h202, 32'hFFFF_3344, F3_SH);
    #1;
    n_cmp++; if (sq_fwd_byte_vector !== 4'b1110) begin n_bad++; $display("FAIL sh_vec got %b want 1110", sq_fwd_byte_vector); end
    n_cmp++; if (sq_fwd_data !== 32'h3344_2200) begin n_bad++; $display("FAIL sh_merge_data got %h want 33442200", sq_fwd_data); end
  endtask

  task automatic test_fill();
    int exp_left[4] = '{3, 2, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(6'(i), 32'h400 + 32'(4 * i), 32'(i + 1), F3_SW);
      n_cmp++; if (sq_left !== 2'(exp_left[i])) begin
        n_bad++; $display("FAIL fill_sq_left[%0d] got %0d want %0d", i, sq_left, exp_left[i]); end
    end
    alloc(6'd4, 32'h300, 32'hDEAD_BEEF, F3_SW);
    load_addr = 32'h300;
    #1;
    n_cmp++; if (sq_left !== 2'd0) begin n_bad++; $display("FAIL full_drop_left got %0d want 0", sq_left); end
    n_cmp++; if (sq_fwd_byte_vector !== 4'h0) begin n_bad++; $display("FAIL full_drop_fwd got %b want 0000", sq_fwd_byte_vector); end
    commit(6'd0);
    n_cmp++; if (mem_write_req !== 1'b1 || mem_write_addr !== 32'h400 || mem_write_data !== 32'd1) begin
      n_bad++; $display("FAIL fill_drain got req=%b addr=%h data=%h want 1/00000400/00000001",
                        mem_write_req, mem_write_addr, mem_write_data); end
    ack_once();
    n_cmp++; if (sq_left !== 2'd1) begin n_bad++; $display("FAIL after_pop_left got %0d want 1", sq_left); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc(6'd5, 32'h500, 32'h55, F3_SW);
    alloc(6'd6, 32'h504, 32'h66, F3_SW);
    alloc(6'd7, 32'h508, 32'h77, F3_SW);
    rob_commit_valid = 1'b1;
    rob_commit_robid = 6'd5;
    flush_valid      = 1'b1;
    flush_robid      = 6'd5;
    tick();
    rob_commit_valid = 1'b0;
    flush_valid      = 1'b0;
    n_cmp++; if (mem_write_req !== 1'b1 || mem_write_addr !== 32'h500 || mem_write_data !== 32'h55) begin
      n_bad++; $display("FAIL flush_head_drains got req=%b addr=%h data=%h want 1/00000500/00000055",
                        mem_write_req, mem_write_addr, mem_write_data); end
    n_cmp++; if (sq_left !== 2'd3) begin n_bad++; $display("FAIL flush_left got %0d want 3", sq_left); end
    load_addr = 32'h504;
    #1;
    n_cmp++; if (sq_fwd_byte_vector !== 4'h0) begin n_bad++; $display("FAIL flush_sq6_gone got %b want 0000", sq_fwd_byte_vector); end
    load_addr = 32'h508;
    #1;
    n_cmp++; if (sq_fwd_byte_vector !== 4'h0) begin n_bad++; $display("FAIL flush_sq7_gone got %b want 0000", sq_fwd_byte_vector); end
    alloc(6'd6, 32'h50C, 32'h99, F3_SW);
    n_cmp++; if (sq_left !== 2'd2) begin n_bad++; $display("FAIL flush_tail_realloc got left=%0d want 2", sq_left); end
    ack_once();
    commit(6'd6);
    n_cmp++; if (mem_write_req !== 1'b1 || mem_write_addr !== 32'h50C || mem_write_data !== 32'h99) begin
      n_bad++; $display("FAIL flush_next_drain got req=%b addr=%h data=%h want 1/0000050c/00000099",
                        mem_write_req, mem_write_addr, mem_write_data); end
  endtask

  task automatic test_drain_stall();
    do_reset();
    alloc(6'd0, 32'h602, 32'h0000_BEEF, F3_SH);
    n_cmp++; if (mem_write_req !== 1'b0) begin n_bad++; $display("FAIL drain_uncommitted_req got %b want 0", mem_write_req); end
    rob_commit_valid = 1'b1;
    rob_commit_robid = 6'd0;
    #1;
    n_cmp++; if (mem_write_req !== 1'b0) begin n_bad++; $display("FAIL drain_commit_cycle_req got %b want 0", mem_write_req); end
    tick();
    rob_commit_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (mem_write_req !== 1'b1 || mem_write_addr !== 32'h600 || mem_write_strb !== 4'b1100 ||
          mem_write_data !== 32'hBEEF_0000) begin
        n_bad++; $display("FAIL drain_stall[%0d] got req=%b addr=%h strb=%b data=%h want 1/00000600/1100/beef0000",
                          c, mem_write_req, mem_write_addr, mem_write_strb, mem_write_data);
      end
      if (c < 3) tick();
    end
    ack_once();
    n_cmp++; if (mem_write_req !== 1'b0 || sq_empty !== 1'b1) begin
      n_bad++; $display("FAIL drain_after_ack got req=%b empty=%b want 0/1", mem_write_req, sq_empty); end
    ack_once();
    n_cmp++; if (sq_left !== 2'd3 || sq_empty !== 1'b1) begin
      n_bad++; $display("FAIL ack_without_req got left=%0d empty=%b want 3/1", sq_left, sq_empty); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    alloc(6'd0, 32'h700, 32'h1, F3_SW);
    alloc(6'd1, 32'h704, 32'h2, F3_SW);
    commit(6'd0);
    n_cmp++; if (mem_write_req !== 1'b1) begin n_bad++; $display("FAIL mid_drain_req_before got %b want 1", mem_write_req); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (mem_write_req !== 1'b0) begin n_bad++; $display("FAIL async_reset_req got %b want 0", mem_write_req); end
    n_cmp++; if (sq_empty !== 1'b1 || sq_left !== 2'd3) begin
      n_bad++; $display("FAIL async_reset_state got empty=%b left=%0d want 1/3", sq_empty, sq_left); end
    n_cmp++; if (mem_write_strb !== 4'h0 || mem_write_addr !== 32'h0) begin
      n_bad++; $display("FAIL async_reset_bus got strb=%b addr=%h want 0000/00000000", mem_write_strb, mem_write_addr); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_sw_forward();
    test_byte_forward();
    test_fill();
    test_flush();
    test_drain_stall();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
